hart_boot_seq: RTL and testbench

HART_BOOT_SEQ -- requirements
Module: hart_boot_seq

---
 rtl/hart_boot_seq_pkg.sv | 26 ++
 rtl/hart_wdt.sv | 50 +++++
 rtl/hart_boot_seq.sv | 177 +++++++++++++++++
 tb/tb_hart_boot_seq.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/hart_boot_seq_pkg.sv
// Shared types for the hart bring-up sequencer: FSM states, interrupt kinds and
// the mapping from (hart, kind) to an interrupt-hold line.
package hart_boot_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_HOLD    = 2'd1,
    ST_RELEASE = 2'd2,
    ST_RUN     = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    IRQ_EXT0  = 2'd0,
    IRQ_EXT1  = 2'd1,
    IRQ_IPI   = 2'd2,
    IRQ_TIMER = 2'd3
  } irq_type_e;

  localparam int IRQ_TYPES = 4;

  // Lines are packed hart-major, so the index equals {hart, kind}.
  function automatic int irq_line(input int hart, input irq_type_e kind);
    return hart * IRQ_TYPES + int'(kind);
  endfunction

endpackage

// File: rtl/hart_wdt.sv
// One per-hart watchdog: saturating idle counter with a sticky hang flag.
// A retire on the cycle the count would reach the limit clears it instead.
module hart_wdt #(
  parameter int WDT_W = 20
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clear_i,
  input  logic             run_i,
  input  logic [WDT_W-1:0] limit_i,
  input  logic             retire_i,
  output logic             hang_o
);

  logic [WDT_W-1:0] cnt_q, cnt_d;
  logic             hang_q, hang_d;
  logic [WDT_W:0]   cnt_inc;
  logic             active;

  always_comb begin
    active  = run_i && (limit_i != '0);
    cnt_inc = {1'b0, cnt_q} + (WDT_W+1)'(1);
    cnt_d   = cnt_q;
    hang_d  = hang_q;
    if (clear_i) begin
      hang_d = 1'b0;
    end
    if (!active || retire_i) begin
      cnt_d = '0;
    end else if (cnt_inc >= {1'b0, limit_i}) begin
      cnt_d  = limit_i;
      hang_d = 1'b1;
    end else begin
      cnt_d = cnt_inc[WDT_W-1:0];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q  <= '0;
      hang_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      hang_q <= hang_d;
    end
  end

  assign hang_o = hang_q;

endmodule

// File: rtl/hart_boot_seq.sv
// Multi-hart boot sequencer: reset hold, staggered hart release, interrupt
// injection and optional per-hart watchdog (enabled by HART_BOOT_SEQ_WDT_EN).
module hart_boot_seq
  import hart_boot_seq_pkg::*;
#(
  parameter int NUM_HARTS = 2,
  parameter int VLEN      = 64,
  parameter int XLEN      = 64,
  parameter int RST_HOLD  = 16,
  parameter int STAGGER   = 4,
  parameter int IRQ_HOLD  = 8,
  parameter int WDT_W     = 20
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      start_i,
  input  logic [VLEN-1:0]           boot_addr_base_i,
  output logic [VLEN-1:0]           boot_addr_o,
  output logic [NUM_HARTS-1:0]      hart_rst_no,
  output logic [NUM_HARTS*XLEN-1:0] hart_id_o,
  input  logic                      irq_req_valid_i,
  output logic                      irq_req_ready_o,
  input  logic [$clog2(NUM_HARTS):0] irq_req_hart_i,
  input  logic [1:0]                irq_req_type_i,
  output logic [NUM_HARTS*2-1:0]    irq_o,
  output logic [NUM_HARTS-1:0]      ipi_o,
  output logic [NUM_HARTS-1:0]      time_irq_o,
  input  logic [NUM_HARTS-1:0]      retire_i,
  input  logic [WDT_W-1:0]          wdt_limit_i,
  output logic [NUM_HARTS-1:0]      hang_o,
  output logic [1:0]                state_o,
  output logic                      done_o
);

  localparam int HART_W   = $clog2(NUM_HARTS) + 1;
  localparam int LINE_W   = HART_W + 2;
  localparam int LINES    = NUM_HARTS * IRQ_TYPES;
  localparam int HOLD_W   = $clog2(IRQ_HOLD + 1);
  localparam int LAST_REL = (NUM_HARTS - 1) * STAGGER;
  localparam int CNT_MAX  = (RST_HOLD > LAST_REL) ? RST_HOLD : LAST_REL;
  localparam int CNT_W    = $clog2(CNT_MAX + 1);

  state_e                        state_q, state_d;
  logic [CNT_W-1:0]              cnt_q, cnt_d;
  logic [VLEN-1:0]               boot_addr_q, boot_addr_d;
  logic [LINES-1:0][HOLD_W-1:0]  irq_cnt_q, irq_cnt_d;
  logic [LINES-1:0]              irq_active;
  logic                          start_accept;
  logic                          req_in_range;
  logic                          req_busy;
  logic                          req_accept;
  logic [LINE_W-1:0]             req_line;
  irq_type_e                     req_type;

  assign start_accept = (state_q == ST_IDLE) && start_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          state_d = ST_HOLD;
          cnt_d   = '0;
        end
      end
      ST_HOLD: begin
        if (cnt_q == CNT_W'(RST_HOLD - 1)) begin
          cnt_d   = '0;
          state_d = (NUM_HARTS == 1) ? ST_RUN : ST_RELEASE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_RELEASE: begin
        if (cnt_q == CNT_W'(LAST_REL - 1)) begin
          cnt_d   = '0;
          state_d = ST_RUN;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: cnt_d = '0;
    endcase
  end

  // Hart k leaves reset once the release counter has reached k*STAGGER.
  always_comb begin
    hart_rst_no = '0;
    for (int k = 0; k < NUM_HARTS; k++) begin
      if (state_q == ST_RUN) begin
        hart_rst_no[k] = 1'b1;
      end else if (state_q == ST_RELEASE) begin
        hart_rst_no[k] = ({1'b0, cnt_q} + (CNT_W+1)'(1)) > (CNT_W+1)'(k * STAGGER);
      end
    end
    done_o  = (state_q == ST_RUN);
    state_o = state_q;
  end

  always_comb begin
    boot_addr_d = start_accept ? boot_addr_base_i : boot_addr_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      boot_addr_q <= '0;
      irq_cnt_q   <= '0;
    end else begin
      boot_addr_q <= boot_addr_d;
      irq_cnt_q   <= irq_cnt_d;
    end
  end

  assign boot_addr_o = boot_addr_q;

  // Out-of-range harts are always ready in RUN and simply match no line.
  always_comb begin
    req_type     = irq_type_e'(irq_req_type_i);
    req_line     = {irq_req_hart_i, req_type};
    req_in_range = irq_req_hart_i < HART_W'(NUM_HARTS);
    req_busy     = 1'b0;
    for (int i = 0; i < LINES; i++) begin
      if (req_in_range && (req_line == LINE_W'(i)) && (irq_cnt_q[i] != '0)) begin
        req_busy = 1'b1;
      end
    end
    irq_req_ready_o = (state_q == ST_RUN) && !req_busy;
    req_accept      = irq_req_valid_i && irq_req_ready_o;
    for (int i = 0; i < LINES; i++) begin
      irq_cnt_d[i]  = (irq_cnt_q[i] != '0) ? irq_cnt_q[i] - HOLD_W'(1) : '0;
      irq_active[i] = (irq_cnt_q[i] != '0);
      if (req_accept && req_in_range && (req_line == LINE_W'(i))) begin
        irq_cnt_d[i] = HOLD_W'(IRQ_HOLD);
      end
    end
  end

  for (genvar k = 0; k < NUM_HARTS; k++) begin : g_hart
    assign hart_id_o[k*XLEN +: XLEN] = XLEN'(k);
    assign irq_o[2*k]                = irq_active[irq_line(k, IRQ_EXT0)];
    assign irq_o[2*k+1]              = irq_active[irq_line(k, IRQ_EXT1)];
    assign ipi_o[k]                  = irq_active[irq_line(k, IRQ_IPI)];
    assign time_irq_o[k]             = irq_active[irq_line(k, IRQ_TIMER)];
  end

`ifdef HART_BOOT_SEQ_WDT_EN
  for (genvar k = 0; k < NUM_HARTS; k++) begin : g_wdt
    hart_wdt #(
      .WDT_W(WDT_W)
    ) u_wdt (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .clear_i (start_accept),
      .run_i   (state_q == ST_RUN),
      .limit_i (wdt_limit_i),
      .retire_i(retire_i[k]),
      .hang_o  (hang_o[k])
    );
  end
`else
  logic unused_wdt;
  assign unused_wdt = ^{wdt_limit_i, retire_i};
  assign hang_o     = '0;
`endif

endmodule

// File: tb/tb_hart_boot_seq.sv
// Directed bench for hart_boot_seq: bring-up timing, interrupt holds,
// out-of-range requests, resets mid-sequence and the watchdog (HART_BOOT_SEQ_WDT_EN).
module tb_hart_boot_seq;

  localparam int NUM_HARTS = 2;
  localparam int VLEN      = 64;
  localparam int XLEN      = 64;
  localparam int WDT_W     = 20;

  logic                      clk_i = 1'b0;
  logic                      rst_i;
  logic                      start_i;
  logic [VLEN-1:0]           boot_addr_base_i;
  logic [VLEN-1:0]           boot_addr_o;
  logic [NUM_HARTS-1:0]      hart_rst_no;
  logic [NUM_HARTS*XLEN-1:0] hart_id_o;
  logic                      irq_req_valid_i;
  logic                      irq_req_ready_o;
  logic [1:0]                irq_req_hart_i;
  logic [1:0]                irq_req_type_i;
  logic [NUM_HARTS*2-1:0]    irq_o;
  logic [NUM_HARTS-1:0]      ipi_o;
  logic [NUM_HARTS-1:0]      time_irq_o;
  logic [NUM_HARTS-1:0]      retire_i;
  logic [WDT_W-1:0]          wdt_limit_i;
  logic [NUM_HARTS-1:0]      hang_o;
  logic [1:0]                state_o;
  logic                      done_o;

  int testCount = 0;
  int failCount = 0;

  localparam logic [63:0] BOOT_A = 64'h8000_0000_1000_0000;
  localparam logic [63:0] BOOT_B = 64'h0000_0000_dead_beef;

  hart_boot_seq #(
    .NUM_HARTS(NUM_HARTS),
    .VLEN     (VLEN),
    .XLEN     (XLEN),
    .RST_HOLD (16),
    .STAGGER  (4),
    .IRQ_HOLD (8),
    .WDT_W    (WDT_W)
  ) dut (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .start_i         (start_i),
    .boot_addr_base_i(boot_addr_base_i),
    .boot_addr_o     (boot_addr_o),
    .hart_rst_no     (hart_rst_no),
    .hart_id_o       (hart_id_o),
    .irq_req_valid_i (irq_req_valid_i),
    .irq_req_ready_o (irq_req_ready_o),
    .irq_req_hart_i  (irq_req_hart_i),
    .irq_req_type_i  (irq_req_type_i),
    .irq_o           (irq_o),
    .ipi_o           (ipi_o),
    .time_irq_o      (time_irq_o),
    .retire_i        (retire_i),
    .wdt_limit_i     (wdt_limit_i),
    .hang_o          (hang_o),
    .state_o         (state_o),
    .done_o          (done_o)
  );

  always #5 clk_i = ~clk_i;

  // Advance n clock edges; outputs are then sampled 1 time unit after the edge.
  task automatic applyStimulus(input int n);
    repeat (n) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  task automatic checkOutput(input string tag, input logic [127:0] observed,
                             input logic [127:0] expected);
    testCount++;
    assert (observed === expected) else begin
      failCount++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic doReset();
    rst_i = 1'b1;
    applyStimulus(1);
    rst_i = 1'b0;
  endtask

  // Start pulse, then 20 more edges: the caller lands on the first RUN cycle.
  task automatic bringUpQuiet(input logic [63:0] addr);
    start_i          = 1'b1;
    boot_addr_base_i = addr;
    applyStimulus(1);
    start_i          = 1'b0;
    boot_addr_base_i = BOOT_B;
    applyStimulus(20);
  endtask

  task automatic sendReq(input logic [1:0] hart, input logic [1:0] kind);
    irq_req_valid_i = 1'b1;
    irq_req_hart_i  = hart;
    irq_req_type_i  = kind;
  endtask

  initial begin
    rst_i            = 1'b1;
    start_i          = 1'b0;
    boot_addr_base_i = '0;
    irq_req_valid_i  = 1'b0;
    irq_req_hart_i   = '0;
    irq_req_type_i   = '0;
    retire_i         = '0;
    wdt_limit_i      = '0;
    applyStimulus(2);

    checkOutput("rst_state", state_o, 0);
    checkOutput("rst_hart_rst", hart_rst_no, 0);
    checkOutput("rst_boot_addr", boot_addr_o, 0);
    checkOutput("rst_irq", irq_o, 0);
    checkOutput("rst_ipi", ipi_o, 0);
    checkOutput("rst_time_irq", time_irq_o, 0);
    checkOutput("rst_hang", hang_o, 0);
    checkOutput("rst_done", done_o, 0);
    checkOutput("rst_ready", irq_req_ready_o, 0);
    checkOutput("hart_id0", hart_id_o[63:0], 0);
    checkOutput("hart_id1", hart_id_o[127:64], 1);
    rst_i = 1'b0;

    // Bring-up: start sampled at edge 0, observations are cycles 1..21.
    start_i          = 1'b1;
    boot_addr_base_i = BOOT_A;
    applyStimulus(1);
    start_i          = 1'b0;
    boot_addr_base_i = BOOT_B;
    checkOutput("boot_addr_latched", boot_addr_o, BOOT_A);
    for (int c = 1; c <= 16; c++) begin
      checkOutput($sformatf("hold_rst_c%0d", c), hart_rst_no, 0);
      checkOutput($sformatf("hold_state_c%0d", c), state_o, 1);
      applyStimulus(1);
    end
    checkOutput("rel_rst_c17", hart_rst_no, 2'b01);
    checkOutput("rel_state_c17", state_o, 2);
    checkOutput("rel_done_c17", done_o, 0);
    for (int c = 18; c <= 20; c++) begin
      applyStimulus(1);
      checkOutput($sformatf("rel_rst_c%0d", c), hart_rst_no, 2'b01);
      checkOutput($sformatf("rel_done_c%0d", c), done_o, 0);
    end
    applyStimulus(1);
    checkOutput("run_rst_c21", hart_rst_no, 2'b11);
    checkOutput("run_done_c21", done_o, 1);
    checkOutput("run_state_c21", state_o, 3);
    checkOutput("run_boot_addr", boot_addr_o, BOOT_A);

    // Start is ignored once running.
    start_i          = 1'b1;
    boot_addr_base_i = BOOT_B;
    applyStimulus(1);
    start_i = 1'b0;
    checkOutput("run_start_state", state_o, 3);
    checkOutput("run_start_boot", boot_addr_o, BOOT_A);

    // Timer interrupt on hart 1 with a blocked repeat during the hold.
    sendReq(2'd1, 2'd3);
    checkOutput("timer_ready", irq_req_ready_o, 1);
    applyStimulus(1);
    irq_req_valid_i = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      checkOutput($sformatf("timer_hold_%0d", i), time_irq_o, 2'b10);
      if (i == 3) begin
        sendReq(2'd1, 2'd3);
        checkOutput("timer_repeat_ready", irq_req_ready_o, 0);
        irq_req_valid_i = 1'b0;
      end
      applyStimulus(1);
    end
    checkOutput("timer_after_hold", time_irq_o, 0);
    sendReq(2'd1, 2'd3);
    checkOutput("timer_ready_again", irq_req_ready_o, 1);
    irq_req_valid_i = 1'b0;

    // External irq[1] on hart 1, then an IPI on hart 0 one cycle later.
    sendReq(2'd1, 2'd1);
    applyStimulus(1);
    sendReq(2'd0, 2'd2);
    applyStimulus(1);
    irq_req_valid_i = 1'b0;
    checkOutput("ext1_hart1", irq_o, 4'b1000);
    checkOutput("ipi_hart0", ipi_o, 2'b01);
    checkOutput("ipi_no_timer", time_irq_o, 0);
    applyStimulus(10);
    checkOutput("ext_cleared", irq_o, 0);
    checkOutput("ipi_cleared", ipi_o, 0);

    // Out-of-range targets: accepted but no output moves.
    sendReq(2'd2, 2'd0);
    checkOutput("oor2_ready", irq_req_ready_o, 1);
    applyStimulus(1);
    sendReq(2'd3, 2'd3);
    checkOutput("oor3_ready", irq_req_ready_o, 1);
    applyStimulus(1);
    irq_req_valid_i = 1'b0;
    checkOutput("oor_irq", irq_o, 0);
    checkOutput("oor_ipi", ipi_o, 0);
    checkOutput("oor_timer", time_irq_o, 0);

    // Reset while running with a live interrupt hold.
    sendReq(2'd0, 2'd3);
    applyStimulus(1);
    checkOutput("pre_rst_timer", time_irq_o, 2'b01);
    rst_i = 1'b1;
    applyStimulus(1);
    rst_i = 1'b0;
    checkOutput("run_rst_timer", time_irq_o, 0);
    checkOutput("run_rst_state", state_o, 0);
    checkOutput("run_rst_harts", hart_rst_no, 0);
    checkOutput("run_rst_ready", irq_req_ready_o, 0);
    checkOutput("run_rst_done", done_o, 0);
    irq_req_valid_i = 1'b0;

    // Reset mid-RELEASE at cycle 19.
    start_i          = 1'b1;
    boot_addr_base_i = BOOT_A;
    applyStimulus(1);
    start_i = 1'b0;
    applyStimulus(18);
    checkOutput("c19_state", state_o, 2);
    checkOutput("c19_harts", hart_rst_no, 2'b01);
    rst_i = 1'b1;
    applyStimulus(1);
    rst_i = 1'b0;
    checkOutput("midrel_state", state_o, 0);
    checkOutput("midrel_harts", hart_rst_no, 0);
    checkOutput("midrel_boot", boot_addr_o, 0);

`ifdef HART_BOOT_SEQ_WDT_EN
    // Watchdog, no retire: hang_o[0] rises 5 cycles after RUN entry.
    wdt_limit_i = 20'd5;
    bringUpQuiet(BOOT_A);
    for (int c = 0; c < 5; c++) begin
      checkOutput($sformatf("wdt_quiet_%0d", c), hang_o[0], 0);
      applyStimulus(1);
    end
    checkOutput("wdt_hang", hang_o[0], 1);
    applyStimulus(3);
    checkOutput("wdt_sticky", hang_o[0], 1);

    // Retire on the limit edge clears the count; the hang comes 5 cycles later.
    doReset();
    checkOutput("wdt_rst_hang", hang_o, 0);
    bringUpQuiet(BOOT_A);
    applyStimulus(4);
    retire_i = 2'b01;
    applyStimulus(1);
    retire_i = 2'b00;
    for (int c = 0; c < 5; c++) begin
      checkOutput($sformatf("wdt_retire_%0d", c), hang_o[0], 0);
      applyStimulus(1);
    end
    checkOutput("wdt_retire_hang", hang_o[0], 1);
`else
    // Without the watchdog, hang_o never rises even with the tightest limit.
    wdt_limit_i = 20'd1;
    bringUpQuiet(BOOT_A);
    checkOutput("nowdt_run", state_o, 3);
    for (int c = 0; c < 1000; c++) begin
      checkOutput($sformatf("nowdt_hang_%0d", c), hang_o, 0);
      applyStimulus(1);
    end
`endif

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
